// File: rtl/cvp14_mem_pkg.sv
// Shared definitions for the CVP14 data memory subsystem: status word
// address, burst tracker state encoding, field widths and a saturating
// burst-length increment.
package cvp14_mem_pkg;

    localparam logic [15:0] STATUS_ADDR = 16'hFFFF;
    localparam int          BURST_LEN_W = 5;
    localparam int          OVF_CNT_W   = 8;

    localparam logic [BURST_LEN_W-1:0] BURST_LEN_MAX = '1;
    localparam logic [OVF_CNT_W-1:0]   OVF_CNT_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RBURST = 2'd1,
        WBURST = 2'd2
    } burst_state_t;

    // Burst length counts up to 31 and then sticks there.
    function automatic logic [BURST_LEN_W-1:0] len_sat_inc(input logic [BURST_LEN_W-1:0] len);
        return (len == BURST_LEN_MAX) ? len : len + 1'b1;
    endfunction

endpackage

// File: rtl/cvp14_ovf_monitor.sv
// Overflow monitor: counts rising edges of the core's V flag into a
// saturating counter and a sticky bit. A synchronous clear (status-word
// write) wins over an edge arriving in the same cycle.
module cvp14_ovf_monitor
    import cvp14_mem_pkg::*;
(
    input  logic                 Clk1,
    input  logic                 Reset,
    input  logic                 V,
    input  logic                 Clr,
    output logic [OVF_CNT_W-1:0] OvfCount,
    output logic                 OvfSticky
);

    logic                 v_d_reg;
    logic [OVF_CNT_W-1:0] ovf_count_reg;
    logic                 ovf_sticky_reg;
    logic                 v_rise;

    assign v_rise = V & ~v_d_reg;

    // Edge detector, saturating counter and sticky bit; clear has priority.
    always_ff @(posedge Clk1) begin
        if (Reset) begin
            v_d_reg        <= 1'b0;
            ovf_count_reg  <= '0;
            ovf_sticky_reg <= 1'b0;
        end else begin
            v_d_reg <= V;
            if (Clr) begin
                ovf_count_reg  <= '0;
                ovf_sticky_reg <= 1'b0;
            end else if (v_rise) begin
                if (ovf_count_reg != OVF_CNT_MAX) begin
                    ovf_count_reg <= ovf_count_reg + 1'b1;
                end
                ovf_sticky_reg <= 1'b1;
            end
        end
    end

    assign OvfCount  = ovf_count_reg;
    assign OvfSticky = ovf_sticky_reg;

endmodule

// File: rtl/cvp14_data_mem.sv
// CVP14 data memory: word-addressed 16-bit backing array with registered
// read, a memory-mapped overflow status word at 16'hFFFF, access error
// reporting and a consecutive-address burst tracker.
// Optional build macro: WRITE_PROTECT_EN -- drops writes below PROT_LIMIT.
module cvp14_data_mem
    import cvp14_mem_pkg::*;
#(
    parameter int          DEPTH_LOG2 = 10,
    parameter logic [15:0] PROT_LIMIT = 16'h0100
)
(
    input  logic                   Clk1,
    input  logic                   Reset,
    input  logic [15:0]            Addr,
    input  logic                   RD,
    input  logic                   WR,
    input  logic [15:0]            WrData,
    input  logic                   V,
    output logic [15:0]            RdData,
    output logic                   AddrErr,
    output logic                   BurstDone,
    output logic [BURST_LEN_W-1:0] BurstLen,
    output logic                   BurstIsWr
);

`ifdef WRITE_PROTECT_EN
    localparam logic PROT_ACTIVE = 1'b1;
`else
    localparam logic PROT_ACTIVE = 1'b0;
`endif

    localparam int DEPTH = 1 << DEPTH_LOG2;

    // Backing store; contents deliberately survive reset.
    logic [15:0] mem [0:DEPTH-1];

    logic [DEPTH_LOG2-1:0]  mem_idx;
    logic                   in_array;
    logic                   is_status;
    logic                   out_of_range;
    logic                   rd_only;
    logic                   prot_hit;
    logic                   mem_we;
    logic                   status_clr;
    logic                   addr_err_next;
    logic [15:0]            status_word;
    logic [OVF_CNT_W-1:0]   ovf_count;
    logic                   ovf_sticky;

    logic [15:0]            rd_data_reg;
    logic                   addr_err_reg;
    burst_state_t           state_reg;
    logic [15:0]            last_addr_reg;
    logic [BURST_LEN_W-1:0] len_reg;
    logic                   burst_done_reg;
    logic [BURST_LEN_W-1:0] burst_len_reg;
    logic                   burst_is_wr_reg;
    logic [15:0]            next_seq_addr;
    logic                   burst_continue;

    // Address decode: array occupies the bottom 2^DEPTH_LOG2 words.
    assign mem_idx      = Addr[DEPTH_LOG2-1:0];
    assign in_array     = (Addr >> DEPTH_LOG2) == 16'd0;
    assign is_status    = (Addr == STATUS_ADDR);
    assign out_of_range = ~in_array & ~is_status;
    assign rd_only      = RD & ~WR;

    // Protection only ever blocks writes; reads and bursts ignore it.
    assign prot_hit   = PROT_ACTIVE & WR & (Addr < PROT_LIMIT);
    assign mem_we     = WR & in_array & ~prot_hit;
    assign status_clr = WR & is_status;

    // Collision, out-of-range access and protected write all flag an error.
    assign addr_err_next = (RD & WR) | ((RD | WR) & out_of_range) | prot_hit;

    assign status_word = {ovf_sticky, 7'b0, ovf_count};

    cvp14_ovf_monitor u_ovf_monitor (
        .Clk1      (Clk1),
        .Reset     (Reset),
        .V         (V),
        .Clr       (status_clr),
        .OvfCount  (ovf_count),
        .OvfSticky (ovf_sticky)
    );

    // Array write port; kept free of reset so it maps onto block RAM.
    always_ff @(posedge Clk1) begin
        if (mem_we && !Reset) begin
            mem[mem_idx] <= WrData;
        end
    end

    // Registered read data; holds whenever there is no read-only access.
    always_ff @(posedge Clk1) begin
        if (Reset) begin
            rd_data_reg <= 16'h0000;
        end else if (rd_only) begin
            if (in_array) begin
                rd_data_reg <= mem[mem_idx];
            end else if (is_status) begin
                rd_data_reg <= status_word;
            end else begin
                rd_data_reg <= 16'h0000;
            end
        end
    end

    // Single-cycle error pulse.
    always_ff @(posedge Clk1) begin
        if (Reset) begin
            addr_err_reg <= 1'b0;
        end else begin
            addr_err_reg <= addr_err_next;
        end
    end

    // A burst continues only with the same access type at the next address
    // (16-bit wrap included). A write with RD also high still counts as a write.
    assign next_seq_addr  = last_addr_reg + 16'd1;
    assign burst_continue = (((state_reg == RBURST) && rd_only) ||
                             ((state_reg == WBURST) && WR)) &&
                            (Addr == next_seq_addr);

    // Burst tracker: extend, or report the finished burst and restart from IDLE
    // rules in the same cycle so back-to-back bursts lose nothing.
    always_ff @(posedge Clk1) begin
        if (Reset) begin
            state_reg       <= IDLE;
            last_addr_reg   <= 16'h0000;
            len_reg         <= '0;
            burst_done_reg  <= 1'b0;
            burst_len_reg   <= '0;
            burst_is_wr_reg <= 1'b0;
        end else begin
            burst_done_reg <= 1'b0;
            if (burst_continue) begin
                len_reg       <= len_sat_inc(len_reg);
                last_addr_reg <= Addr;
            end else begin
                if (state_reg != IDLE) begin
                    burst_done_reg  <= 1'b1;
                    burst_len_reg   <= len_reg;
                    burst_is_wr_reg <= (state_reg == WBURST);
                end
                if (WR) begin
                    state_reg     <= WBURST;
                    len_reg       <= BURST_LEN_W'(1);
                    last_addr_reg <= Addr;
                end else if (RD) begin
                    state_reg     <= RBURST;
                    len_reg       <= BURST_LEN_W'(1);
                    last_addr_reg <= Addr;
                end else begin
                    state_reg <= IDLE;
                    len_reg   <= '0;
                end
            end
        end
    end

    assign RdData    = rd_data_reg;
    assign AddrErr   = addr_err_reg;
    assign BurstDone = burst_done_reg;
    assign BurstLen  = burst_len_reg;
    assign BurstIsWr = burst_is_wr_reg;

endmodule

// File: tb/tb_cvp14_data_mem.sv
// Scoreboard bench for cvp14_data_mem: the driver applies one access per
// cycle, a behavioural model predicts the outputs after that edge and
// queues them; a monitor pops one prediction per clock and compares.
module tb_cvp14_data_mem;

    localparam logic [15:0] TB_PROT_LIMIT = 16'h0100;
    localparam int          TB_DEPTH      = 1024;

    logic        Clk1 = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] Addr = 16'h0000;
    logic        RD = 1'b0;
    logic        WR = 1'b0;
    logic [15:0] WrData = 16'h0000;
    logic        V = 1'b0;
    logic [15:0] RdData;
    logic        AddrErr;
    logic        BurstDone;
    logic [4:0]  BurstLen;
    logic        BurstIsWr;

    cvp14_data_mem dut (
        .Clk1      (Clk1),
        .Reset     (Reset),
        .Addr      (Addr),
        .RD        (RD),
        .WR        (WR),
        .WrData    (WrData),
        .V         (V),
        .RdData    (RdData),
        .AddrErr   (AddrErr),
        .BurstDone (BurstDone),
        .BurstLen  (BurstLen),
        .BurstIsWr (BurstIsWr)
    );

    always #5 Clk1 = ~Clk1;

    typedef struct packed {
        logic [15:0] rd;
        logic        err;
        logic        done;
        logic [4:0]  len;
        logic        iswr;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference state, kept in plain terms: memory words, overflow count,
    // and the current run of same-type consecutive accesses.
    logic [15:0] ref_mem [0:TB_DEPTH-1];
    logic [15:0] ref_rd = 16'h0000;
    int          ref_cnt = 0;
    bit          ref_sticky = 0;
    bit          ref_vprev = 0;
    int          run_kind = 0;     // 0 none, 1 reads, 2 writes
    int          run_len = 0;
    int          run_last = 0;

    function automatic bit wp_enabled();
`ifdef WRITE_PROTECT_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic exp_t model_step(input bit rst, input bit rd, input bit wr,
                                        input logic [15:0] a, input logic [15:0] d, input bit v);
        exp_t e;
        bit   in_arr, is_stat, oor, prot, clr, rise;
        int   kind;
        e = '0;
        if (rst) begin
            ref_rd = 16'h0000; ref_cnt = 0; ref_sticky = 0; ref_vprev = 0;
            run_kind = 0; run_len = 0; run_last = 0;
            return e;
        end
        in_arr  = (int'(a) < TB_DEPTH);
        is_stat = (a == 16'hFFFF);
        oor     = !in_arr && !is_stat;
        prot    = wp_enabled() && wr && (a < TB_PROT_LIMIT);
        e.err   = (rd && wr) || ((rd || wr) && oor) || prot;
        if (rd && !wr) begin
            if (in_arr)       ref_rd = ref_mem[int'(a)];
            else if (is_stat) ref_rd = {ref_sticky, 7'b0, 8'(ref_cnt)};
            else              ref_rd = 16'h0000;
        end
        e.rd = ref_rd;
        if (wr && in_arr && !prot) ref_mem[int'(a)] = d;
        clr  = wr && is_stat;
        rise = v && !ref_vprev;
        ref_vprev = v;
        if (clr) begin
            ref_cnt = 0; ref_sticky = 0;
        end else if (rise) begin
            ref_cnt = (ref_cnt < 255) ? ref_cnt + 1 : 255;
            ref_sticky = 1;
        end
        kind = wr ? 2 : (rd ? 1 : 0);
        if (run_kind != 0 && kind == run_kind && int'(a) == ((run_last + 1) % 65536)) begin
            run_len++;
            run_last = int'(a);
        end else begin
            if (run_kind != 0) begin
                e.done = 1'b1;
                e.len  = 5'((run_len > 31) ? 31 : run_len);
                e.iswr = (run_kind == 2);
            end
            run_kind = kind;
            run_len  = (kind != 0) ? 1 : 0;
            run_last = int'(a);
        end
        return e;
    endfunction

    task automatic cyc(input bit rst, input bit rd, input bit wr,
                       input logic [15:0] a, input logic [15:0] d, input bit v);
        @(negedge Clk1);
        Reset = rst; RD = rd; WR = wr; Addr = a; WrData = d; V = v;
        exp_q.push_back(model_step(rst, rd, wr, a, d, v));
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
        end
    endtask

    // Monitor: one prediction per clock, compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge Clk1);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("RdData",    RdData,            e.rd);
                chk("AddrErr",   {15'b0, AddrErr},  {15'b0, e.err});
                chk("BurstDone", {15'b0, BurstDone}, {15'b0, e.done});
                if (e.done) begin
                    chk("BurstLen",  {11'b0, BurstLen},  {11'b0, e.len});
                    chk("BurstIsWr", {15'b0, BurstIsWr}, {15'b0, e.iswr});
                end
            end
        end
    end

    initial begin
        logic [15:0] a;
        logic [15:0] specials [0:3];
        bit          vv;
        int          op;
        specials[0] = 16'hFFFF; specials[1] = 16'h8000;
        specials[2] = 16'h03FF; specials[3] = 16'h0400;

        cyc(1, 0, 0, 16'h0000, 16'h0000, 0);
        cyc(1, 0, 0, 16'h0000, 16'h0000, 0);

        // Fill the whole array: one long write burst, length saturates at 31.
        for (int i = 0; i < TB_DEPTH; i++) cyc(0, 0, 1, 16'(i), 16'($urandom), 0);
        cyc(0, 0, 0, 16'h0000, 16'h0000, 0);

        // Write then read back the same word.
        cyc(0, 0, 1, 16'h0010, 16'h3C00, 0);
        cyc(0, 1, 0, 16'h0010, 16'h0000, 0);
        cyc(0, 0, 0, 16'h0000, 16'h0000, 0);

        // 16-word read burst.
        for (int i = 0; i < 16; i++) cyc(0, 1, 0, 16'h0020 + 16'(i), 16'h0000, 0);
        cyc(0, 0, 0, 16'h0000, 16'h0000, 0);

        // Write burst of 2 followed immediately by a read burst.
        cyc(0, 0, 1, 16'h0040, 16'h1111, 0);
        cyc(0, 0, 1, 16'h0041, 16'h2222, 0);
        cyc(0, 1, 0, 16'h0042, 16'h0000, 0);
        cyc(0, 0, 0, 16'h0000, 16'h0000, 0);

        // Overflow monitor: clear, two rising edges, read, clear, read.
        cyc(0, 0, 1, 16'hFFFF, 16'h1234, 0);
        cyc(0, 0, 0, 16'h0000, 16'h0000, 1);
        cyc(0, 0, 0, 16'h0000, 16'h0000, 1);
        cyc(0, 0, 0, 16'h0000, 16'h0000, 1);
        cyc(0, 0, 0, 16'h0000, 16'h0000, 0);
        cyc(0, 0, 0, 16'h0000, 16'h0000, 1);
        cyc(0, 1, 0, 16'hFFFF, 16'h0000, 1);
        cyc(0, 0, 1, 16'hFFFF, 16'h0000, 1);
        cyc(0, 1, 0, 16'hFFFF, 16'h0000, 0);
        cyc(0, 0, 0, 16'h0000, 16'h0000, 0);

        // Out-of-range read and RD/WR collision.
        cyc(0, 1, 0, 16'h8000, 16'h0000, 0);
        cyc(0, 1, 1, 16'h0005, 16'hBEEF, 0);
        cyc(0, 1, 0, 16'h0005, 16'h0000, 0);
        cyc(0, 0, 0, 16'h0000, 16'h0000, 0);

        // Reset on the fifth beat of a read burst.
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 16'h0100 + 16'(i), 16'h0000, 0);
        cyc(1, 1, 0, 16'h0104, 16'h0000, 0);
        cyc(0, 0, 0, 16'h0000, 16'h0000, 0);

        // Write below the protection limit, then read it back.
        cyc(0, 0, 1, 16'h0005, 16'h5A5A, 0);
        cyc(0, 1, 0, 16'h0005, 16'h0000, 0);
        cyc(0, 0, 0, 16'h0000, 16'h0000, 0);

        // Burst across the 16'hFFFF -> 16'h0000 wrap.
        cyc(0, 1, 0, 16'hFFFF, 16'h0000, 0);
        cyc(0, 1, 0, 16'h0000, 16'h0000, 0);
        cyc(0, 0, 0, 16'h0000, 16'h0000, 0);

        // Randomized traffic biased towards sequential addresses.
        a = 16'h0000; vv = 0;
        for (int n = 0; n < 4000; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5, 6: a = a + 16'd1;
                7:       a = 16'($urandom_range(0, 63));
                8:       a = specials[$urandom_range(0, 3)];
                default: a = 16'($urandom_range(0, TB_DEPTH - 1));
            endcase
            if ($urandom_range(0, 7) == 0) vv = ~vv;
            op = $urandom_range(0, 19);
            if ($urandom_range(0, 299) == 0)
                cyc(1, 0, 0, a, 16'h0000, vv);
            else if (op < 4)
                cyc(0, 0, 0, a, 16'h0000, vv);
            else if (op < 11)
                cyc(0, 1, 0, a, 16'h0000, vv);
            else if (op < 19)
                cyc(0, 0, 1, a, 16'($urandom), vv);
            else
                cyc(0, 1, 1, a, 16'($urandom), vv);
        end
        cyc(0, 0, 0, 16'h0000, 16'h0000, 0);
        cyc(0, 0, 0, 16'h0000, 16'h0000, 0);

        // Bounded drain of the scoreboard.
        for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(posedge Clk1);
        #2;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d predictions left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cvp14_data_mem.md
Name: cvp14_data_mem

Overview:
Word-addressed 16-bit memory subsystem that sits directly downstream of the CVP14 core. It serves the core's Addr/RD/WR/dataOut bus and returns read data to the core's DataIn one cycle later. It also monitors the core's V (overflow) output into a memory-mapped status word. It tracks consecutive-address bursts from vector loads and stores and reports them for debug and performance counting.

Parameters:
DEPTH_LOG2, 10, log2 of backing array depth in 16-bit words (1024 words).
PROT_LIMIT, 16'h0100, first writable address when WRITE_PROTECT_EN is defined.

Ports:
Clk1  in  1  sole clock; all state updates on posedge.
Reset  in  1  synchronous, active-high reset.
Addr  in  16  word address from core.
RD  in  1  read strobe.
WR  in  1  write strobe.
WrData  in  16  write data, driven from the core's dataOut.
V  in  1  core overflow flag, level.
RdData  out  16  registered read data, connected to the core's DataIn.
AddrErr  out  1  one-cycle pulse on an out-of-range access or RD&WR collision.
BurstDone  out  1  one-cycle pulse when a burst terminates.
BurstLen  out  5  length of the burst just terminated; valid while BurstDone=1.
BurstIsWr  out  1  1 = terminated burst was a write burst; valid while BurstDone=1.

Behaviour:
- Reset (Clk1 edge with Reset=1): RdData=0, AddrErr=0, BurstDone=0, BurstLen=0, BurstIsWr=0, OvfCount=0, OvfSticky=0, V_d=0, FSM=IDLE. Array contents are not cleared. Reset overrides any simultaneous access.
- Read: RD=1, WR=0 at edge n -> RdData <= mem[Addr] at edge n, so data is visible to the core from cycle n+1. RdData holds its value when RD=0.
- Write: WR=1 at edge n -> mem[Addr] <= WrData. A read of the same address in cycle n+1 returns the new value.
- RD=1 and WR=1 together: the write executes, RdData holds, AddrErr pulses.
- Address decode:
  - Addr < 2^DEPTH_LOG2: backing array.
  - Addr == 16'hFFFF: status word. Read returns {OvfSticky, 7'b0, OvfCount[7:0]}. Write of any value clears OvfCount and OvfSticky.
  - Any other address is out of range: read returns 16'h0000, write is dropped, AddrErr pulses.
- Overflow monitor:
  - V_d registered each cycle.
  - Rising edge (V & ~V_d) -> OvfCount increments, saturating at 8'hFF; OvfSticky <= 1.
  - A status-write clear in the same cycle as a rising edge takes priority; the result is 0/0.
- Burst FSM, states IDLE, RBURST, WBURST; registers LastAddr[15:0] and Len[4:0]:
  - IDLE: RD-only -> RBURST, Len=1, LastAddr=Addr. WR (alone or with RD) -> WBURST, Len=1. No access -> stay in IDLE.
  - RBURST with RD-only and Addr==LastAddr+1 (16-bit wrap, 16'hFFFF -> 16'h0000 counts as consecutive): Len <= sat31(Len+1), LastAddr <= Addr.
  - WBURST: same rule, using WR.
  - Any other cycle while in a burst (no access, opposite type, or non-consecutive address) terminates it:
    - BurstDone=1, BurstLen=Len, BurstIsWr=(state==WBURST) in the next cycle.
    - The same cycle's access is then evaluated as if the FSM were in IDLE, so back-to-back bursts lose no cycle.
  - Len saturates at 31.
  - Reset mid-burst: the FSM returns to IDLE and no BurstDone is emitted.
- Out-of-range and status-word accesses still participate in burst tracking.

Optional Feature:
WRITE_PROTECT_EN
- Defined: writes with Addr < PROT_LIMIT are dropped and pulse AddrErr. Reads are unaffected. Burst tracking is unaffected.
- Undefined: the whole array is writable, and PROT_LIMIT is unused.

Decomposition:
- Package cvp14_mem_pkg:
  - STATUS_ADDR = 16'hFFFF.
  - Burst state encoding IDLE=2'd0, RBURST=2'd1, WBURST=2'd2.
  - BURST_LEN_W = 5, OVF_CNT_W = 8.
- Sub-module cvp14_ovf_monitor: V edge detect, saturating counter, sticky bit, synchronous clear input. Instanced once.
- Burst FSM and array stay in the top module.

Test Plan:
1. Write 16'h3C00 to 0x0010, then RD 0x0010 next cycle -> RdData=16'h3C00 one cycle after the RD edge; AddrErr stays 0.
2. 16 consecutive RDs from 0x0020 to 0x002F, then one idle cycle -> exactly one BurstDone with BurstLen=16, BurstIsWr=0.
3. WR 0x0040, WR 0x0041, then RD 0x0042 in the next cycle -> BurstDone with BurstLen=2, BurstIsWr=1, and a new read burst starts with Len=1.
4. Pulse V high for 3 cycles, low, then high again; read 0xFFFF -> RdData=16'h8002. Write 0xFFFF, then read again -> 16'h0000.
5. RD 0x8000 (out of range) -> RdData=0 and an AddrErr pulse. RD&WR together at 0x0005 -> write executes, RdData unchanged, AddrErr pulse.
6. Assert Reset during the 5th cycle of a read burst -> no BurstDone; all outputs return to their reset values. With WRITE_PROTECT_EN defined, WR to 0x0005 is dropped and AddrErr pulses.
